// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: D = A - B - BIN, one 4-bit borrow-lookahead slice per clock,
// least-significant nibble first, with a start/busy/done handshake and held results.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             ZERO,
    output logic             OVF
);
    // state  | meaning
    // S_IDLE | waiting for START, results held
    // S_RUN  | one nibble slice evaluated per clock

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    logic [0:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             borrow;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] d_nib;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Borrow lookahead: generate where a=0,b=1; propagate where a==b.
    always_comb begin
        a_nib = 4'(a_reg >> {idx, 2'b00});
        b_nib = 4'(b_reg >> {idx, 2'b00});
        g     = ~a_nib & b_nib;
        p     = ~(a_nib ^ b_nib);
        c[0]  = borrow;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d_nib = a_nib ^ b_nib ^ c[3:0];
        // res_reg is cleared on start, so OR-ing the slice into place is enough
        res_next = res_reg | (WIDTH'(d_nib) << {idx, 2'b00});
    end

    assign BUSY = (state == S_RUN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            idx     <= '0;
            borrow  <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            DONE    <= 1'b0;
            D       <= '0;
            BOUT    <= 1'b0;
            ZERO    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        borrow  <= BIN;
                        idx     <= '0;
                        res_reg <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_reg <= res_next;
                    borrow  <= c[4];
                    if (idx == LAST_IDX) begin
                        state <= S_IDLE;
                        D     <= res_next;
                        BOUT  <= c[4];
                        ZERO  <= (res_next == '0);
                        OVF   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                 (res_next[WIDTH-1] != a_reg[WIDTH-1]);
                        DONE  <= 1'b1;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: arithmetic reference model with per-cycle compare on a
// 16-bit and an 8-bit instance, plus directed cases with hand-computed results.
module tb_nibble_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start16, bin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, bout16, zero16, ovf16;
    logic [15:0] d16;

    logic        start8, bin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, bout8, zero8, ovf8;
    logic [7:0]  d8;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .CLK(clk), .RESET(rst), .START(start16), .A(a16), .B(b16), .BIN(bin16),
        .BUSY(busy16), .DONE(done16), .D(d16), .BOUT(bout16), .ZERO(zero16), .OVF(ovf16)
    );

    nibble_serial_subtractor #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8), .ZERO(zero8), .OVF(ovf8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {bout, zero, ovf, d[31:0]} for a w-bit subtraction a - b - bin.
    function automatic logic [34:0] ref_sub(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic bin);
        logic [31:0] mask, dd;
        logic [32:0] full;
        logic        bo, z, o, sa, sb;
        mask = (32'd1 << w) - 32'd1;
        a    = a & mask;
        b    = b & mask;
        full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        dd   = full[31:0] & mask;
        bo   = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
        z    = (dd == 32'd0);
        sa   = a[w-1];
        sb   = b[w-1];
        o    = (sa != sb) && (dd[w-1] != sa);
        return {bo, z, o, dd};
    endfunction

    // Model: an accepted request completes N clocks later; results update only then.
    int          m16_cnt = 0;
    logic        m16_done = 1'b0, m16_bout = 1'b0, m16_zero = 1'b0, m16_ovf = 1'b0;
    logic [15:0] m16_d = '0;
    logic [34:0] m16_pend = '0;

    int          m8_cnt = 0;
    logic        m8_done = 1'b0, m8_bout = 1'b0, m8_zero = 1'b0, m8_ovf = 1'b0;
    logic [7:0]  m8_d = '0;
    logic [34:0] m8_pend = '0;

    always @(posedge clk) begin
        m16_done = 1'b0;
        m8_done  = 1'b0;
        if (rst) begin
            m16_cnt = 0; m16_d = '0; m16_bout = 0; m16_zero = 0; m16_ovf = 0;
            m8_cnt  = 0; m8_d  = '0; m8_bout  = 0; m8_zero  = 0; m8_ovf  = 0;
        end else begin
            if (m16_cnt == 0) begin
                if (start16) begin
                    m16_pend = ref_sub(16, {16'd0, a16}, {16'd0, b16}, bin16);
                    m16_cnt  = 4;
                end
            end else begin
                m16_cnt--;
                if (m16_cnt == 0) begin
                    {m16_bout, m16_zero, m16_ovf} = m16_pend[34:32];
                    m16_d    = m16_pend[15:0];
                    m16_done = 1'b1;
                end
            end
            if (m8_cnt == 0) begin
                if (start8) begin
                    m8_pend = ref_sub(8, {24'd0, a8}, {24'd0, b8}, bin8);
                    m8_cnt  = 2;
                end
            end else begin
                m8_cnt--;
                if (m8_cnt == 0) begin
                    {m8_bout, m8_zero, m8_ovf} = m8_pend[34:32];
                    m8_d    = m8_pend[7:0];
                    m8_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy16", {31'd0, busy16}, {31'd0, m16_cnt > 0});
            check("done16", {31'd0, done16}, {31'd0, m16_done});
            check("d16",    {16'd0, d16},    {16'd0, m16_d});
            check("bout16", {31'd0, bout16}, {31'd0, m16_bout});
            check("zero16", {31'd0, zero16}, {31'd0, m16_zero});
            check("ovf16",  {31'd0, ovf16},  {31'd0, m16_ovf});
            check("busy8",  {31'd0, busy8},  {31'd0, m8_cnt > 0});
            check("done8",  {31'd0, done8},  {31'd0, m8_done});
            check("d8",     {24'd0, d8},     {24'd0, m8_d});
            check("bout8",  {31'd0, bout8},  {31'd0, m8_bout});
            check("zero8",  {31'd0, zero8},  {31'd0, m8_zero});
            check("ovf8",   {31'd0, ovf8},   {31'd0, m8_ovf});
        end
    end

    task automatic wait_done16(input string name);
        int k = 0;
        while (!done16 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, k, 4);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; bin16 = bin;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
        wait_done16("latency16");
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int k = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency8", k, 2);
    endtask

    task automatic expect16(input string name, input logic [15:0] d, input logic bo,
                            input logic z, input logic o);
        check({name, "_d"},    {16'd0, d16}, {16'd0, d});
        check({name, "_bout"}, {31'd0, bout16}, {31'd0, bo});
        check({name, "_zero"}, {31'd0, zero16}, {31'd0, z});
        check({name, "_ovf"},  {31'd0, ovf16}, {31'd0, o});
    endtask

    initial begin
        logic [34:0] r;
        rst = 1'b1;
        start16 = 0; a16 = '0; b16 = '0; bin16 = 0;
        start8  = 0; a8  = '0; b8  = '0; bin8  = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        expect16("reset", 16'h0000, 0, 0, 0);
        check("reset_busy", {31'd0, busy16}, 32'd0);
        rst = 1'b0;

        // Pin the reference model to hand-computed values.
        r = ref_sub(16, 32'h1234, 32'h0235, 1'b0);
        check("model_a", {29'd0, r[34:32]}, 32'd0);
        check("model_a_d", r[31:0], 32'h0FFF);
        r = ref_sub(16, 32'h8000, 32'h0001, 1'b0);
        check("model_ovf", {29'd0, r[34:32]}, 32'd1);

        issue16(16'h1234, 16'h0235, 1'b0);
        expect16("t1", 16'h0FFF, 0, 0, 0);
        issue16(16'h0000, 16'h0001, 1'b0);
        expect16("t2", 16'hFFFF, 1, 0, 0);
        issue16(16'h8000, 16'h0001, 1'b0);
        expect16("t3a", 16'h7FFF, 0, 0, 1);
        issue16(16'h5555, 16'h5554, 1'b1);
        expect16("t3b", 16'h0000, 0, 1, 0);

        // Restart pulse while busy must be ignored.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h0235; bin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000;
        @(negedge clk);
        start16 = 1'b0;
        begin
            int k = 0;
            while (!done16 && k < 20) begin @(negedge clk); k++; end
            check("ignore_latency", k, 2);
        end
        expect16("t4a", 16'h0FFF, 0, 0, 0);
        // START held high in the DONE cycle: accepted back-to-back.
        start16 = 1'b1; a16 = 16'h0010; b16 = 16'h0001; bin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        wait_done16("b2b_latency");
        expect16("t4b", 16'h000F, 0, 0, 0);

        // Reset in the second RUN cycle aborts with no DONE.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h4321; b16 = 16'h1111; bin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy16}, 32'd0);
        check("abort_done", {31'd0, done16}, 32'd0);
        expect16("abort", 16'h0000, 0, 0, 0);
        repeat (6) @(negedge clk);
        issue16(16'h4321, 16'h1111, 1'b0);
        expect16("t5", 16'h3210, 0, 0, 0);

        // 8-bit instance: directed then mixed random sweep.
        issue8(8'h10, 8'h01, 1'b0);
        check("w8_d1", {24'd0, d8}, 32'h0F);
        issue8(8'h00, 8'h01, 1'b0);
        check("w8_d2", {24'd0, d8}, 32'hFF);
        check("w8_bout2", {31'd0, bout8}, 32'd1);
        issue8(8'h80, 8'h01, 1'b0);
        check("w8_ovf3", {31'd0, ovf8}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom));
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        issue16(16'hFFFF, 16'hFFFF, 1'b1);
        expect16("edge_ff", 16'hFFFF, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
